step_pulse_gen: RTL and testbench

- Upstream stage of the board-level processor wrapper. Turns the raw step push-button and run switch into clean single-cycle step strobes that drive the datapath's manual clock input.
- Synchronizes and debounces the button and emits exactly one `step_pulse` per debounced press.
- Optionally free-runs at a fixed step period while the run switch is on.
- Keeps a wrap-around step counter for display on LEDs or seven-segment.

---
 rtl/step_pulse_gen_if.sv | 31 +++
 rtl/step_pulse_gen.sv | 144 ++++++++++++++
 tb/tb_step_pulse_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/step_pulse_gen_if.sv
// Step pulse generator pin bundle: raw button/run inputs in,
// debounced level, step strobe and step count out.
//   btn_in, run_en     : raw asynchronous inputs (driven by master)
//   step_pulse         : one-cycle step strobe
//   btn_level          : debounced button level
//   step_count         : wrap-around step counter
interface step_pulse_gen_if #(
    parameter int COUNT_W = 16
);
    logic               btn_in;
    logic               run_en;
    logic               step_pulse;
    logic               btn_level;
    logic [COUNT_W-1:0] step_count;

    modport master (
        output btn_in,
        output run_en,
        input  step_pulse,
        input  btn_level,
        input  step_count
    );

    modport slave (
        input  btn_in,
        input  run_en,
        output step_pulse,
        output btn_level,
        output step_count
    );
endinterface

// File: rtl/step_pulse_gen.sv
// Debounced manual step / free-running step strobe generator.
// Ports: clk, rst (sync active-high), bus (step_pulse_gen_if.slave).
module step_pulse_gen #(
    parameter int STABLE_COUNT = 1000000,
    parameter int RUN_PERIOD   = 50000000,
    parameter int COUNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    step_pulse_gen_if.slave  bus
);
    localparam int CNT_W = $clog2(STABLE_COUNT);
    localparam int PER_W = $clog2(RUN_PERIOD);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(RUN_PERIOD - 1);
    localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic               btn_meta;
    logic               btn_sync;
    logic               run_meta;
    logic               run_sync;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               level;
    logic               level_nxt;
    logic               press;

    logic [PER_W-1:0]   per;
    logic [PER_W-1:0]   per_nxt;
    logic               auto_step;

    logic               pulse;
    logic [COUNT_W-1:0] count;

    // Debounce: a level change is accepted only after STABLE_COUNT
    // consecutive agreeing synchronized samples.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        press     = 1'b0;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press     = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

    // Period counter parks at zero while run is off, so the first
    // automatic step always lands a full period after run engages.
    always_comb begin
        per_nxt   = '0;
        auto_step = 1'b0;
        if (run_sync) begin
            if (per == PER_LAST) begin
                auto_step = 1'b1;
            end else begin
                per_nxt = per + PER_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            run_meta <= 1'b0;
            run_sync <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            level    <= 1'b0;
            per      <= '0;
            pulse    <= 1'b0;
            count    <= '0;
        end else begin
            btn_meta <= bus.btn_in;
            btn_sync <= btn_meta;
            run_meta <= bus.run_en;
            run_sync <= run_meta;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            level    <= level_nxt;
            per      <= per_nxt;
            // Coincident press and auto strobes merge into one step.
            pulse    <= press | auto_step;
            if (press | auto_step) begin
                count <= count + 1'b1;
            end
        end
    end

    assign bus.step_pulse = pulse;
    assign bus.btn_level  = level;
    assign bus.step_count = count;
endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen with small parameters.
// Stimulus pushes expected pulses; a negedge monitor checks them.
module tb_step_pulse_gen;
    typedef struct {
        int         cyc;
        logic [3:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    logic prev_pulse;
    logic [3:0] exp_cnt;
    exp_t q[$];

    step_pulse_gen_if #(.COUNT_W(4)) bus ();

    step_pulse_gen #(
        .STABLE_COUNT(4),
        .RUN_PERIOD  (8),
        .COUNT_W     (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic to_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cyc %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input int at);
        exp_t e;
        exp_cnt = exp_cnt + 4'd1;
        e.cyc = at;
        e.cnt = exp_cnt;
        q.push_back(e);
    endtask

    // Monitor: pop and compare every observed pulse; flag missed ones.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse got none want cyc %0d", e.cyc);
        end
        if (bus.step_pulse) begin
            checks++;
            if (prev_pulse) begin
                errors++;
                $display("FAIL consecutive_pulse got 1 want 0 (cyc %0d)", cyc);
            end
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got cyc %0d want none", cyc);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.cnt != bus.step_count) begin
                    errors++;
                    $display("FAIL pulse got cyc %0d cnt %0d want cyc %0d cnt %0d",
                             cyc, bus.step_count, e.cyc, e.cnt);
                end
            end
        end
        prev_pulse = bus.step_pulse;
    end

    initial begin
        int e0;
        int r0;
        logic pat [6];
        checks     = 0;
        errors     = 0;
        exp_cnt    = 4'd0;
        prev_pulse = 1'b0;
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // 1: reset with button held
        rst        = 1'b1;
        bus.btn_in = 1'b1;
        bus.run_en = 1'b0;
        to_cyc(1);
        chk("rst_pulse", int'(bus.step_pulse), 0);
        chk("rst_level", int'(bus.btn_level), 0);
        chk("rst_count", int'(bus.step_count), 0);
        to_cyc(3);
        chk("rst_count3", int'(bus.step_count), 0);
        rst = 1'b0;
        expect_pulse(cyc + 6);
        to_cyc(cyc + 5);
        chk("t1_level_pre", int'(bus.btn_level), 0);
        to_cyc(cyc + 2);
        chk("t1_level", int'(bus.btn_level), 1);
        chk("t1_count", int'(bus.step_count), 1);
        e0 = cyc;
        bus.btn_in = 1'b0;
        to_cyc(e0 + 5);
        chk("t1_rel_hold", int'(bus.btn_level), 1);
        to_cyc(e0 + 6);
        chk("t1_rel_fall", int'(bus.btn_level), 0);
        to_cyc(e0 + 10);

        // 2: clean press, hold, release
        e0 = cyc;
        bus.btn_in = 1'b1;
        expect_pulse(e0 + 6);
        to_cyc(e0 + 5);
        chk("t2_level_pre", int'(bus.btn_level), 0);
        to_cyc(e0 + 6);
        chk("t2_level_rise", int'(bus.btn_level), 1);
        to_cyc(e0 + 20);
        r0 = cyc;
        bus.btn_in = 1'b0;
        to_cyc(r0 + 5);
        chk("t2_level_hold", int'(bus.btn_level), 1);
        to_cyc(r0 + 6);
        chk("t2_level_fall", int'(bus.btn_level), 0);
        chk("t2_count", int'(bus.step_count), 2);
        to_cyc(r0 + 10);

        // 3: bounce on press after reset
        rst = 1'b1;
        to_cyc(cyc + 2);
        rst = 1'b0;
        exp_cnt = 4'd0;
        chk("t3_rst_count", int'(bus.step_count), 0);
        e0 = cyc;
        for (int i = 0; i < 6; i++) begin
            bus.btn_in = pat[i];
            to_cyc(e0 + i + 1);
        end
        bus.btn_in = 1'b1;
        expect_pulse(e0 + 12);
        to_cyc(e0 + 11);
        chk("t3_level_pre", int'(bus.btn_level), 0);
        to_cyc(e0 + 13);
        chk("t3_level", int'(bus.btn_level), 1);
        chk("t3_count", int'(bus.step_count), 1);
        bus.btn_in = 1'b0;
        to_cyc(cyc + 10);

        // 4: run mode alone, then stop
        e0 = cyc;
        bus.run_en = 1'b1;
        expect_pulse(e0 + 10);
        expect_pulse(e0 + 18);
        expect_pulse(e0 + 26);
        to_cyc(e0 + 27);
        bus.run_en = 1'b0;
        to_cyc(e0 + 50);
        chk("t4_count", int'(bus.step_count), 4);

        // 5: press coincides with auto strobe
        e0 = cyc;
        bus.run_en = 1'b1;
        expect_pulse(e0 + 10);
        to_cyc(e0 + 12);
        bus.btn_in = 1'b1;
        expect_pulse(e0 + 18);
        expect_pulse(e0 + 26);
        to_cyc(e0 + 20);
        bus.btn_in = 1'b0;
        to_cyc(e0 + 27);
        bus.run_en = 1'b0;
        to_cyc(e0 + 47);
        chk("t5_count", int'(bus.step_count), 7);

        // 6: wrap of the step counter
        rst = 1'b1;
        to_cyc(cyc + 2);
        rst = 1'b0;
        exp_cnt = 4'd0;
        e0 = cyc;
        bus.run_en = 1'b1;
        for (int k = 0; k < 17; k++) begin
            expect_pulse(e0 + 10 + 8 * k);
        end
        to_cyc(e0 + 10 + 8 * 16 + 3);
        bus.run_en = 1'b0;
        to_cyc(cyc + 20);
        chk("t6_count", int'(bus.step_count), 1);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_empty got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
